dsp_wb_arb: RTL and testbench
=============================

DSP_WB_ARB -- requirements
Module: dsp_wb_arb

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, consecutive blocked cycles before the external requester is forced through.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 wb_en  in  1  pipeline writeback request from the WB stage, one write per cycle when high.
REQ-005 wb_addr  in  REG_ADDR_LEN  pipeline destination register.
REQ-006 wb_data  in  REG_WORD_LEN  pipeline write data.
REQ-007 ext_req  in  1  external (host/DMA) write request, level, held until ext_ack.
REQ-008 ext_addr  in  REG_ADDR_LEN  external destination register, stable while ext_req high.
REQ-009 ext_data  in  REG_WORD_LEN  external write data, stable while ext_req high.
REQ-010 ext_ack  out  1  one-cycle pulse: external write issued this cycle.
REQ-011 pipe_stall  out  1  one-cycle request to the pipeline to suppress wb_en on the next cycle.
REQ-012 rf_we  out  1  registered register-file write enable.
REQ-013 rf_addr  out  REG_ADDR_LEN  registered write address.
REQ-014 rf_wdata  out  REG_WORD_LEN  registered write data.
REQ-015 stall_err  out  1  sticky flag: wb_en seen in a cycle where the pipeline was told to stall.

Function
REQ-016 Arbitration decided each cycle from inputs; winner appears on rf_we/rf_addr/rf_wdata one cycle later (latency 1).
REQ-017 Pipeline priority: wb_en high always wins; pipeline writes are never dropped or delayed.
REQ-018 wb_en low and ext request eligible -> external granted; ext_ack high same cycle rf_we shows the external write.
REQ-019 ext_req ignored in the cycle ext_ack is high (requester drops it next cycle); no double write.
REQ-020 FSM states: IDLE (no pending ext), WAIT (ext pending, blocked by pipeline), STALL (pipe_stall asserted, ext forced).
REQ-021 IDLE -> WAIT: ext_req high and wb_en high; IDLE stays IDLE when ext granted directly.
REQ-022 WAIT: starve counter increments per blocked cycle; counter == STARVE_LIMIT -> STALL, pipe_stall registered high for exactly one cycle.
REQ-023 STALL -> next cycle: wb_en low -> ext granted, back to IDLE; wb_en high -> pipeline wins, stall_err set, back to WAIT with counter cleared.
REQ-024 Any state: ext_req low -> IDLE, counter cleared, pipe_stall low.
REQ-025 Counter width ceil(log2(STARVE_LIMIT+1)), saturates, never wraps.
REQ-026 Same-address conflict: pipeline write issued first, external write lands later; later write wins in register file.
REQ-027 rf_we low in any cycle with no grant; rf_addr/rf_wdata hold last value.
REQ-028 stall_err cleared only by reset.

Reset
REQ-029 rst_n low: FSM IDLE, counter 0, rf_we 0, rf_addr 0, rf_wdata 0, ext_ack 0, pipe_stall 0, stall_err 0, immediately.
REQ-030 Reset mid-operation abandons pending ext request; requester re-presents after release; no ack issued for it.
REQ-031 First grant possible on the first rising edge after rst_n release.

Structure
REQ-032 REG_WORD_LEN, REG_ADDR_LEN, FSM state encodings in the shared definitions include.
REQ-033 Single flat module; no sub-module; STARVE_LIMIT local parameter override per instance.

Verification
REQ-034 wb_en=1, wb_addr=5, wb_data=0x1234, no ext -> next cycle rf_we=1, rf_addr=5, rf_wdata=0x1234, ext_ack=0.
REQ-035 ext_req=1 addr=7 data=0xBEEF, wb_en=0 -> next cycle rf_we=1, rf_addr=7, ext_ack=1 single pulse; ext_req dropped -> no second write.
REQ-036 ext_req held, wb_en=1 continuously, STARVE_LIMIT=3 -> pipe_stall high one cycle after 3 blocked cycles; bench drops wb_en -> ext_ack next cycle.
REQ-037 Same as 036 but wb_en kept high in stall cycle -> pipeline write issued, stall_err=1 sticky, counter restarts, second pipe_stall after 3 more cycles.
REQ-038 rst_n pulled low while in WAIT with counter=2 -> all outputs 0 at once; after release, re-presented ext_req granted in IDLE.

Source files
------------

// File: rtl/dsp_wb_arb_pkg.sv
// Shared definitions for the register-file writeback arbiter: word and
// address widths, their types, and the arbiter FSM state encodings.
package dsp_wb_arb_pkg;

    localparam int REG_WORD_LEN = 16;
    localparam int REG_ADDR_LEN = 5;

    typedef logic [REG_WORD_LEN-1:0] reg_word_t;
    typedef logic [REG_ADDR_LEN-1:0] reg_addr_t;

    // IDLE: no external write pending; WAIT: external write blocked by the
    // pipeline; STALL: pipe_stall is out, external write is being forced.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

endpackage

// File: rtl/dsp_wb_arb_if.sv
// Bus bundle between the pipeline WB stage / external host and the
// register-file write arbiter.
//
// Handshakes: wb_en is a one-cycle write with no back-pressure (always
// accepted). ext_req is a level request with ext_addr/ext_data stable while
// high; the arbiter answers with a one-cycle ext_ack in the same cycle the
// external write shows on rf_we, and the requester drops ext_req the cycle
// after. pipe_stall asks the pipeline to hold wb_en low.
interface dsp_wb_arb_if;
    import dsp_wb_arb_pkg::*;

    logic      wb_en;
    reg_addr_t wb_addr;
    reg_word_t wb_data;
    logic      ext_req;
    reg_addr_t ext_addr;
    reg_word_t ext_data;
    logic      ext_ack;
    logic      pipe_stall;
    logic      rf_we;
    reg_addr_t rf_addr;
    reg_word_t rf_wdata;
    logic      stall_err;

    modport slave (
        input  wb_en, wb_addr, wb_data, ext_req, ext_addr, ext_data,
        output ext_ack, pipe_stall, rf_we, rf_addr, rf_wdata, stall_err
    );

    modport master (
        output wb_en, wb_addr, wb_data, ext_req, ext_addr, ext_data,
        input  ext_ack, pipe_stall, rf_we, rf_addr, rf_wdata, stall_err
    );

endinterface

// File: rtl/dsp_wb_arb.sv
// Register-file write-port arbiter. The pipeline always wins; an external
// requester waits, and after STARVE_LIMIT blocked cycles the pipeline is
// asked to stall for one cycle so the external write can go through.
// Winner is registered onto rf_we/rf_addr/rf_wdata (latency 1).
module dsp_wb_arb
    import dsp_wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    dsp_wb_arb_if.slave bus,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIMIT);

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             stall_n;
    logic             ext_ok;
    logic             grant_ext;

    // The request is ignored in its ack cycle: the requester still holds it
    // high there, and honouring it would write the same data twice.
    assign ext_ok    = bus.ext_req && !bus.ext_ack;
    assign grant_ext = !bus.wb_en && ext_ok;
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign dbg_state = state;

    // Next-state / starve-counter logic.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall_n = 1'b0;
        if (!ext_ok || grant_ext) begin
            // Nothing pending, or the external write goes out now.
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else if (state == ST_STALL) begin
            // Pipeline ignored the stall: it still wins, starve count restarts.
            state_n = ST_WAIT;
            cnt_n   = '0;
        end else if (cnt_inc >= CNT_LIM) begin
            state_n = ST_STALL;
            cnt_n   = cnt_inc;
            stall_n = 1'b1;
        end else begin
            state_n = ST_WAIT;
            cnt_n   = cnt_inc;
        end
    end

    // FSM state, counter and the registered stall request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            bus.pipe_stall <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            bus.pipe_stall <= stall_n;
        end
    end

    // Registered register-file write port; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rf_we    <= 1'b0;
            bus.rf_addr  <= '0;
            bus.rf_wdata <= '0;
            bus.ext_ack  <= 1'b0;
        end else begin
            bus.rf_we   <= bus.wb_en || grant_ext;
            bus.ext_ack <= grant_ext;
            if (bus.wb_en) begin
                bus.rf_addr  <= bus.wb_addr;
                bus.rf_wdata <= bus.wb_data;
            end else if (grant_ext) begin
                bus.rf_addr  <= bus.ext_addr;
                bus.rf_wdata <= bus.ext_data;
            end
        end
    end

    // Sticky flag: the pipeline wrote during the cycle it was told to stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.stall_err <= 1'b0;
        end else if (state == ST_STALL && bus.wb_en) begin
            bus.stall_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dsp_wb_arb.sv
// Self-checking bench for dsp_wb_arb: directed arbitration scenarios plus a
// random pipeline burst, with a write scoreboard on the register-file port.
module tb_dsp_wb_arb;
    import dsp_wb_arb_pkg::*;

    localparam int W = REG_ADDR_LEN + REG_WORD_LEN;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [W-1:0] exp_q[$];

    dsp_wb_arb_if bus ();

    dsp_wb_arb #(.STARVE_LIMIT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every rf write must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && bus.rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", 32'(bus.rf_addr), 32'hFFFF_FFFF);
            end else begin
                check("sb_write", 32'({bus.rf_addr, bus.rf_wdata}), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic en, input reg_addr_t a, input reg_word_t d);
        bus.wb_en   = en;
        bus.wb_addr = a;
        bus.wb_data = d;
        if (en) exp_q.push_back({a, d});
    endtask

    task automatic drive_ext(input logic req, input reg_addr_t a, input reg_word_t d);
        bus.ext_req  = req;
        bus.ext_addr = a;
        bus.ext_data = d;
    endtask

    task automatic expect_ext_grant();
        exp_q.push_back({bus.ext_addr, bus.ext_data});
    endtask

    task automatic drive_wb_rand();
        drive_wb(1'b1, reg_addr_t'($urandom_range(0, 31)), reg_word_t'($urandom_range(0, 65535)));
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_rf_we"},      32'(bus.rf_we),      32'd0);
        check({pfx, "_rf_addr"},    32'(bus.rf_addr),    32'd0);
        check({pfx, "_rf_wdata"},   32'(bus.rf_wdata),   32'd0);
        check({pfx, "_ext_ack"},    32'(bus.ext_ack),    32'd0);
        check({pfx, "_pipe_stall"}, 32'(bus.pipe_stall), 32'd0);
        check({pfx, "_stall_err"},  32'(bus.stall_err),  32'd0);
        check({pfx, "_state"},      32'(dbg_state),      32'(ST_IDLE));
    endtask

    initial begin
        rst_n = 1'b0;
        drive_wb(1'b0, '0, '0);
        drive_ext(1'b0, '0, '0);
        #23;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // pipeline write
        drive_wb(1'b1, 5'd5, 16'h1234);
        tick();
        check("wb_rf_we", 32'(bus.rf_we), 32'd1);
        check("wb_rf_addr", 32'(bus.rf_addr), 32'd5);
        check("wb_rf_wdata", 32'(bus.rf_wdata), 32'h1234);
        check("wb_ext_ack", 32'(bus.ext_ack), 32'd0);
        drive_wb(1'b0, '0, '0);
        tick();
        check("idle_rf_we", 32'(bus.rf_we), 32'd0);
        check("idle_addr_hold", 32'(bus.rf_addr), 32'd5);
        check("idle_data_hold", 32'(bus.rf_wdata), 32'h1234);

        // direct external grant; ext_req still high in the ack cycle
        drive_ext(1'b1, 5'd7, 16'hBEEF);
        expect_ext_grant();
        tick();
        check("ext_ack", 32'(bus.ext_ack), 32'd1);
        check("ext_rf_we", 32'(bus.rf_we), 32'd1);
        check("ext_rf_addr", 32'(bus.rf_addr), 32'd7);
        check("ext_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        check("ext_ack_pulse", 32'(bus.ext_ack), 32'd0);
        check("ext_no_double", 32'(bus.rf_we), 32'd0);
        drive_ext(1'b0, '0, '0);
        tick();

        // starvation -> stall -> pipeline complies
        drive_ext(1'b1, 5'd9, 16'hA5A5);
        for (int i = 0; i < 3; i++) begin
            drive_wb_rand();
            tick();
            check("starve_ext_ack", 32'(bus.ext_ack), 32'd0);
            check("starve_pipe_stall", 32'(bus.pipe_stall), (i == 2) ? 32'd1 : 32'd0);
            check("starve_state", 32'(dbg_state), (i == 2) ? 32'(ST_STALL) : 32'(ST_WAIT));
        end
        drive_wb(1'b0, '0, '0);
        expect_ext_grant();
        tick();
        check("forced_ext_ack", 32'(bus.ext_ack), 32'd1);
        check("forced_pipe_stall_low", 32'(bus.pipe_stall), 32'd0);
        check("forced_state", 32'(dbg_state), 32'(ST_IDLE));
        check("forced_no_err", 32'(bus.stall_err), 32'd0);
        tick();
        check("forced_ack_pulse", 32'(bus.ext_ack), 32'd0);
        drive_ext(1'b0, '0, '0);
        tick();

        // starvation -> stall ignored -> stall_err, second stall
        // (same address as the external write: pipeline write lands first)
        drive_ext(1'b1, 5'd3, 16'hCAFE);
        drive_wb(1'b1, 5'd3, 16'h0001);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive_wb_rand();
            tick();
        end
        check("stall1", 32'(bus.pipe_stall), 32'd1);
        drive_wb_rand();
        tick();
        check("ignored_err", 32'(bus.stall_err), 32'd1);
        check("ignored_no_ack", 32'(bus.ext_ack), 32'd0);
        check("ignored_pipe_stall_low", 32'(bus.pipe_stall), 32'd0);
        check("ignored_state", 32'(dbg_state), 32'(ST_WAIT));
        for (int i = 0; i < 3; i++) begin
            drive_wb_rand();
            tick();
            check("restart_pipe_stall", 32'(bus.pipe_stall), (i == 2) ? 32'd1 : 32'd0);
        end
        drive_wb(1'b0, '0, '0);
        expect_ext_grant();
        tick();
        check("second_ext_ack", 32'(bus.ext_ack), 32'd1);
        check("second_rf_addr", 32'(bus.rf_addr), 32'd3);
        check("second_rf_wdata", 32'(bus.rf_wdata), 32'hCAFE);
        drive_ext(1'b0, '0, '0);
        tick();
        check("err_sticky", 32'(bus.stall_err), 32'd1);

        // random pipeline-only burst: nothing dropped, order preserved
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 1) drive_wb_rand();
            else drive_wb(1'b0, '0, '0);
            tick();
            check("burst_no_ack", 32'(bus.ext_ack), 32'd0);
        end
        drive_wb(1'b0, '0, '0);
        tick();

        // reset while waiting with counter at 2
        drive_ext(1'b1, 5'd12, 16'h0F0F);
        drive_wb_rand();
        tick();
        drive_wb_rand();
        tick();
        check("pre_reset_state", 32'(dbg_state), 32'(ST_WAIT));
        drive_wb(1'b0, '0, '0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick();
        check("reset_no_ack", 32'(bus.ext_ack), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive_ext(1'b1, 5'd12, 16'h0F0F);
        expect_ext_grant();
        tick();
        check("post_reset_ack", 32'(bus.ext_ack), 32'd1);
        check("post_reset_rf_we", 32'(bus.rf_we), 32'd1);
        drive_ext(1'b0, '0, '0);
        tick();
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
